// File: rtl/track_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : track_sequencer
// Purpose  : Two-track record/playback controller with live-key arbitration.
// Revision : 1.0
// ============================================================================
module track_sequencer #(
    parameter int DEPTH       = 9,
    parameter int STEP_CYCLES = 12500000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [8:0] keys,
    input  logic [1:0] rec_sel,
    input  logic [1:0] play_sel,
    output logic [8:0] note_out,
    output logic [2:0] code_out,
    output logic       busy,
    output logic       done,
    output logic [3:0] count1,
    output logic [3:0] count2
);

    localparam int             TW        = $clog2(STEP_CYCLES);
    localparam logic [TW-1:0]  STEP_LAST = TW'(STEP_CYCLES - 1);
    localparam logic [3:0]     DEPTH_L   = 4'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REC  = 2'd1,
        S_PLAY = 2'd2
    } state_t;

    function automatic logic is_onehot(input logic [8:0] v);
        return (v != 9'd0) && ((v & (v - 9'd1)) == 9'd0);
    endfunction

    function automatic logic [2:0] note_code(input logic [8:0] v);
        case (v)
            9'h100:  return 3'b001;
            9'h080:  return 3'b010;
            9'h040:  return 3'b100;
            9'h020:  return 3'b110;
            9'h010, 9'h008, 9'h004, 9'h002, 9'h001: return 3'b011;
            default: return 3'b000;
        endcase
    endfunction

    state_t         state, state_nx;
    logic [8:0]     key_q;
    logic           press;
    logic [8:0]     press_key;
    logic [1:0]     play_q;
    logic           rec_trk, rec_trk_nx;
    logic           trk, trk_nx;
    logic [3:0]     idx, idx_nx;
    logic           valid, valid_nx;
    logic           chain, chain_nx;
    logic [TW-1:0]  timer, timer_nx;
    logic [3:0]     cnt1_nx, cnt2_nx;
    logic [8:0]     note_nx;
    logic           done_nx;
    logic           wr_en;

    logic [8:0]     mem1 [16];
    logic [8:0]     mem2 [16];

    logic           live_hot;
    logic [8:0]     live_note;
    logic           rec_valid;
    logic           play_rise;
    logic [3:0]     cur_count;
    logic [8:0]     play_note;

    assign live_hot  = is_onehot(keys);
    assign live_note = live_hot ? keys : 9'd0;
    assign rec_valid = (rec_sel == 2'b01) || (rec_sel == 2'b10);
    assign play_rise = (play_q == 2'b00) && (play_sel != 2'b00);
    assign cur_count = trk ? count2 : count1;
    assign play_note = trk ? mem2[idx] : mem1[idx];

    always_comb begin
        state_nx   = state;
        rec_trk_nx = rec_trk;
        trk_nx     = trk;
        idx_nx     = idx;
        valid_nx   = valid;
        chain_nx   = chain;
        timer_nx   = timer;
        cnt1_nx    = count1;
        cnt2_nx    = count2;
        note_nx    = live_note;
        done_nx    = 1'b0;
        wr_en      = 1'b0;

        case (state)
            S_IDLE: begin
                if (rec_valid) begin
                    state_nx   = S_REC;
                    rec_trk_nx = rec_sel[1];
                    if (rec_sel[1]) cnt2_nx = 4'd0;
                    else            cnt1_nx = 4'd0;
                end else if (play_rise) begin
                    state_nx = S_PLAY;
                    chain_nx = play_sel[1];
                    idx_nx   = 4'd0;
                    timer_nx = '0;
                    // Empty selected tracks are skipped before the first step.
                    if (play_sel[0] && count1 != 4'd0) begin
                        trk_nx   = 1'b0;
                        valid_nx = 1'b1;
                    end else if (play_sel[1] && count2 != 4'd0) begin
                        trk_nx   = 1'b1;
                        valid_nx = 1'b1;
                    end else begin
                        trk_nx   = 1'b0;
                        valid_nx = 1'b0;
                    end
                end
            end

            S_REC: begin
                if (rec_sel != {rec_trk, ~rec_trk})
                    state_nx = S_IDLE;
                if (press) begin
                    if (rec_trk) begin
                        if (count2 < DEPTH_L) begin
                            wr_en   = 1'b1;
                            cnt2_nx = count2 + 4'd1;
                        end
                    end else begin
                        if (count1 < DEPTH_L) begin
                            wr_en   = 1'b1;
                            cnt1_nx = count1 + 4'd1;
                        end
                    end
                end
            end

            S_PLAY: begin
                if (rec_valid || play_sel == 2'b00) begin
                    state_nx = S_IDLE;
                end else if (!valid) begin
                    state_nx = S_IDLE;
                    done_nx  = 1'b1;
                end else begin
                    if (!live_hot)
                        note_nx = play_note;
                    if (timer == STEP_LAST) begin
                        timer_nx = '0;
                        if (idx + 4'd1 < cur_count) begin
                            idx_nx = idx + 4'd1;
                        end else if (!trk && chain && count2 != 4'd0) begin
                            trk_nx = 1'b1;
                            idx_nx = 4'd0;
                        end else begin
                            valid_nx = 1'b0;
                        end
                    end else begin
                        timer_nx = timer + TW'(1);
                    end
                end
            end

            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            key_q     <= 9'd0;
            press     <= 1'b0;
            press_key <= 9'd0;
            play_q    <= 2'b00;
            rec_trk   <= 1'b0;
            trk       <= 1'b0;
            idx       <= 4'd0;
            valid     <= 1'b0;
            chain     <= 1'b0;
            timer     <= '0;
            count1    <= 4'd0;
            count2    <= 4'd0;
            note_out  <= 9'd0;
            code_out  <= 3'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            key_q     <= keys;
            press     <= is_onehot(keys) && (keys != key_q);
            press_key <= keys;
            play_q    <= play_sel;
            rec_trk   <= rec_trk_nx;
            trk       <= trk_nx;
            idx       <= idx_nx;
            valid     <= valid_nx;
            chain     <= chain_nx;
            timer     <= timer_nx;
            count1    <= cnt1_nx;
            count2    <= cnt2_nx;
            note_out  <= note_nx;
            code_out  <= note_code(note_nx);
            busy      <= (state_nx != S_IDLE);
            done      <= done_nx;
        end
    end

    // Storage needs no reset: entries beyond the counts are never read.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            if (rec_trk) mem2[count2] <= press_key;
            else         mem1[count1] <= press_key;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_track_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_track_sequencer
// Purpose  : Directed self-checking bench for track_sequencer.
// Revision : 1.0
// ============================================================================
module tb_track_sequencer;

    localparam int DEPTH = 3;
    localparam int STEP  = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic [8:0] keys;
    logic [1:0] rec_sel;
    logic [1:0] play_sel;
    logic [8:0] note_out;
    logic [2:0] code_out;
    logic       busy;
    logic       done;
    logic [3:0] count1;
    logic [3:0] count2;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    track_sequencer #(.DEPTH(DEPTH), .STEP_CYCLES(STEP)) dut (
        .clock    (clock),
        .reset    (reset),
        .keys     (keys),
        .rec_sel  (rec_sel),
        .play_sel (play_sel),
        .note_out (note_out),
        .code_out (code_out),
        .busy     (busy),
        .done     (done),
        .count1   (count1),
        .count2   (count2)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; keys = 9'd0; rec_sel = 2'b00; play_sel = 2'b00;
        step(2);
        n_cmp++;
        if ({note_out, code_out, busy, done, count1, count2} !== 23'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0", {note_out, code_out, busy, done, count1, count2});
        end
        reset = 1'b1;
        step(2);
        n_cmp++;
        if (busy !== 1'b0 || count1 !== 4'd0 || count2 !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b c1=%0d c2=%0d want 0/0/0", busy, count1, count2);
        end
    endtask

    task automatic test_record;
        rec_sel = 2'b01;
        step(1);
        n_cmp++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL rec_busy: got %b want 1", busy); end
        keys = 9'h100;
        #1;
        n_cmp++;
        if (code_out !== 3'b000) begin n_fail++; $display("FAIL live_latency_pre: got %b want 000", code_out); end
        step(1);
        n_cmp++;
        if (code_out !== 3'b001 || note_out !== 9'h100) begin
            n_fail++; $display("FAIL live_q: got %b/%h want 001/100", code_out, note_out);
        end
        step(1);
        n_cmp++;
        if (count1 !== 4'd1) begin n_fail++; $display("FAIL rec_q_count: got %0d want 1", count1); end
        step(8);
        n_cmp++;
        if (count1 !== 4'd1) begin n_fail++; $display("FAIL rec_hold_count: got %0d want 1", count1); end
        keys = 9'd0;
        step(2);
        keys = 9'h080;
        step(1);
        n_cmp++;
        if (code_out !== 3'b010) begin n_fail++; $display("FAIL live_w: got %b want 010", code_out); end
        step(1);
        n_cmp++;
        if (count1 !== 4'd2) begin n_fail++; $display("FAIL rec_w_count: got %0d want 2", count1); end
        keys = 9'h040;   // key-to-key without release
        step(2);
        n_cmp++;
        if (count1 !== 4'd3 || code_out !== 3'b100) begin
            n_fail++; $display("FAIL rec_e_count: got %0d/%b want 3/100", count1, code_out);
        end
        keys = 9'd0;
        step(1);
        keys = 9'h020;
        step(1);
        n_cmp++;
        if (code_out !== 3'b110) begin n_fail++; $display("FAIL live_r: got %b want 110", code_out); end
        step(2);
        n_cmp++;
        if (count1 !== 4'd3) begin n_fail++; $display("FAIL rec_full: got %0d want 3", count1); end
        keys = 9'd0;
        rec_sel = 2'b00;
        step(1);
        n_cmp++;
        if (busy !== 1'b0 || count1 !== 4'd3) begin
            n_fail++; $display("FAIL rec_exit: busy=%b c1=%0d want 0/3", busy, count1);
        end
    endtask

    task automatic test_playback;
        logic [8:0] exp;
        play_sel = 2'b01;
        step(1);
        n_cmp++;
        if (busy !== 1'b1 || note_out !== 9'd0) begin
            n_fail++; $display("FAIL play_entry: busy=%b note=%h want 1/000", busy, note_out);
        end
        for (int i = 0; i < 3 * STEP; i++) begin
            step(1);
            exp = (i < STEP) ? 9'h100 : (i < 2 * STEP) ? 9'h080 : 9'h040;
            n_cmp++;
            if (note_out !== exp || done !== 1'b0) begin
                n_fail++; $display("FAIL play_step%0d: note=%h done=%b want %h/0", i, note_out, done, exp);
            end
        end
        step(1);
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || note_out !== 9'd0) begin
            n_fail++; $display("FAIL play_done: done=%b busy=%b note=%h want 1/0/000", done, busy, note_out);
        end
        step(1);
        n_cmp++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL play_done_pulse: got %b want 0", done); end
        play_sel = 2'b00;
        step(1);
    endtask

    task automatic test_chained;
        logic [2:0] exp;
        int         dones;
        rec_sel = 2'b10;
        step(1);
        keys = 9'h010;
        step(1);
        keys = 9'd0;
        step(2);
        rec_sel = 2'b00;
        step(1);
        n_cmp++;
        if (count2 !== 4'd1 || count1 !== 4'd3) begin
            n_fail++; $display("FAIL rec_track2: c1=%0d c2=%0d want 3/1", count1, count2);
        end
        play_sel = 2'b11;
        step(1);
        dones = 0;
        for (int i = 0; i < 4 * STEP; i++) begin
            step(1);
            exp = (i < STEP) ? 3'b001 : (i < 2 * STEP) ? 3'b010 : (i < 3 * STEP) ? 3'b100 : 3'b011;
            if (done === 1'b1) dones++;
            n_cmp++;
            if (code_out !== exp || busy !== 1'b1) begin
                n_fail++; $display("FAIL chain_step%0d: code=%b busy=%b want %b/1", i, code_out, busy, exp);
            end
        end
        step(1);
        if (done === 1'b1) dones++;
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL chain_done: done=%b busy=%b want 1/0", done, busy);
        end
        step(2);
        if (done === 1'b1) dones++;
        n_cmp++;
        if (dones !== 1) begin n_fail++; $display("FAIL chain_done_count: got %0d want 1", dones); end
        play_sel = 2'b00;
        step(1);
    endtask

    task automatic test_arbitration_abort;
        play_sel = 2'b01;
        step(1 + STEP);
        n_cmp++;
        if (code_out !== 3'b001) begin n_fail++; $display("FAIL arb_step1: got %b want 001", code_out); end
        step(1);
        n_cmp++;
        if (code_out !== 3'b010) begin n_fail++; $display("FAIL arb_step2: got %b want 010", code_out); end
        keys = 9'h001;
        for (int i = 0; i < 2; i++) begin
            step(1);
            n_cmp++;
            if (code_out !== 3'b011 || note_out !== 9'h001) begin
                n_fail++; $display("FAIL arb_live%0d: got %b/%h want 011/001", i, code_out, note_out);
            end
        end
        keys = 9'd0;
        step(1);
        n_cmp++;
        if (code_out !== 3'b010) begin n_fail++; $display("FAIL arb_resume: got %b want 010", code_out); end
        step(1);
        n_cmp++;
        if (code_out !== 3'b100) begin n_fail++; $display("FAIL arb_timer_kept: got %b want 100", code_out); end
        play_sel = 2'b00;
        step(1);
        n_cmp++;
        if (busy !== 1'b0 || note_out !== 9'd0 || done !== 1'b0) begin
            n_fail++; $display("FAIL abort: busy=%b note=%h done=%b want 0/000/0", busy, note_out, done);
        end
        for (int i = 0; i < 3; i++) begin
            step(1);
            n_cmp++;
            if (done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done%0d: got %b want 0", i, done); end
        end
    endtask

    task automatic test_edge_cases;
        rec_sel = 2'b10;
        step(2);
        keys = 9'h180;
        step(3);
        n_cmp++;
        if (count2 !== 4'd0 || code_out !== 3'b000 || note_out !== 9'd0) begin
            n_fail++; $display("FAIL chord: c2=%0d code=%b note=%h want 0/000/000", count2, code_out, note_out);
        end
        keys = 9'd0;
        rec_sel = 2'b00;
        step(1);
        play_sel = 2'b10;
        step(1);
        n_cmp++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++; $display("FAIL empty_entry: busy=%b done=%b want 1/0", busy, done);
        end
        step(1);
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL empty_done: done=%b busy=%b want 1/0", done, busy);
        end
        play_sel = 2'b00;
        step(1);
        rec_sel = 2'b11;
        step(4);
        n_cmp++;
        if (busy !== 1'b0 || count1 !== 4'd3 || count2 !== 4'd0) begin
            n_fail++; $display("FAIL rec11: busy=%b c1=%0d c2=%0d want 0/3/0", busy, count1, count2);
        end
        rec_sel = 2'b00;
        step(1);
    endtask

    task automatic test_reset_mid_play;
        play_sel = 2'b01;
        step(3);
        n_cmp++;
        if (note_out !== 9'h100 || busy !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset_play: note=%h busy=%b want 100/1", note_out, busy);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({note_out, code_out, busy, done, count1, count2} !== 23'd0) begin
            n_fail++; $display("FAIL reset_async: got %h want 0", {note_out, code_out, busy, done, count1, count2});
        end
        play_sel = 2'b00;
        step(2);
        reset = 1'b1;
        step(2);
        n_cmp++;
        if (busy !== 1'b0 || count1 !== 4'd0 || count2 !== 4'd0 || note_out !== 9'd0) begin
            n_fail++; $display("FAIL reset_release: busy=%b c1=%0d c2=%0d note=%h want 0/0/0/000", busy, count1, count2, note_out);
        end
    endtask

    initial begin
        test_reset();
        test_record();
        test_playback();
        test_chained();
        test_arbitration_abort();
        test_edge_cases();
        test_reset_mid_play();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
